uart_tx: RTL

- 8-N-1 UART transmitter, LSB first, idle-high line; the transmit-side counterpart of the team's 16x-oversampling UART receiver on the same host link.
- Accepts bytes over a valid/ready handshake into a small FIFO and serialises them.
- Bit timing comes from a fractional NCO phase accumulator, so no integer clock divider is required.
- Sits between the on-chip result/packet formatter and the board TX pin going to the host-side Python tool.

---
 rtl/uart_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 UART transmitter (LSB first, idle-high line).
// Bytes arrive over a valid/ready handshake into a small FIFO. A fractional
// NCO phase accumulator produces the bit-rate tick, so clk_hz need not be an
// integer multiple of baud.
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active low
//   in_data  byte to send
//   in_valid in_data is valid; a push happens when in_valid && in_ready
//   in_ready FIFO can accept a byte (not full)
//   tx_o     registered serial line, idle high
//   busy     frame in progress or FIFO non-empty
//   done     one-cycle pulse at the end of each frame's last stop bit
module uart_tx #(
  parameter int unsigned clk_hz    = 50_000_000,
  parameter int unsigned baud      = 115_200,
  parameter int unsigned ACC_width = 24,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_o,
  output logic       busy,
  output logic       done
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Rounded phase increment: baud * 2^ACC_width / clk_hz, in 64-bit arithmetic.
  localparam logic [63:0] INCR64 =
    ((64'(baud) << ACC_width) + 64'(clk_hz / 2)) / 64'(clk_hz);
  localparam logic [ACC_width-1:0] INCR = INCR64[ACC_width-1:0];

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // ----------------------------------------------------------------- NCO
  logic [ACC_width-1:0] phase, phase_n;
  logic [ACC_width:0]   sum;
  logic                 baud_tick;

  assign sum       = {1'b0, phase} + {1'b0, INCR};
  assign baud_tick = sum[ACC_width];

  // ------------------------------------------------------ frame datapath
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_index, bit_index_n;
  logic [1:0] stop_count, stop_count_n;
  logic       tx_n, done_n;

  always_comb begin
    state_n      = state;
    tx_n         = tx_o;
    done_n       = 1'b0;
    shreg_n      = shreg;
    bit_index_n  = bit_index;
    stop_count_n = stop_count;
    pop          = 1'b0;
    // Accumulator is parked at zero while idle so the first bit is full length.
    phase_n      = (state == IDLE) ? '0 : sum[ACC_width-1:0];

    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = head;
          tx_n    = 1'b0;
          phase_n = '0;
          state_n = START;
        end
      end

      START: begin
        if (baud_tick) begin
          tx_n        = shreg[0];
          bit_index_n = '0;
          state_n     = DATA;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_index == 3'd7) begin
            tx_n         = 1'b1;
            stop_count_n = '0;
            state_n      = STOP;
          end else begin
            shreg_n     = shreg >> 1;
            tx_n        = shreg[1];
            bit_index_n = bit_index + 3'd1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (32'(stop_count) < STOP_BITS - 1) begin
            stop_count_n = stop_count + 2'd1;
          end else begin
            done_n = 1'b1;
            // Chain straight into the next start bit when data is waiting.
            if (!empty) begin
              pop     = 1'b1;
              shreg_n = head;
              tx_n    = 1'b0;
              phase_n = '0;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_o       <= 1'b1;
      done       <= 1'b0;
      phase      <= '0;
      shreg      <= '0;
      bit_index  <= '0;
      stop_count <= '0;
    end else begin
      state      <= state_n;
      tx_o       <= tx_n;
      done       <= done_n;
      phase      <= phase_n;
      shreg      <= shreg_n;
      bit_index  <= bit_index_n;
      stop_count <= stop_count_n;
    end
  end

  assign busy = (state != IDLE) || !empty;

endmodule
